spiker_writer: RTL

Return-path packer for the spiker accelerator: accepts one N_SPIKES-bit result vector from the spiker core through a valid/ready handshake. It then writes that vector into the register file as consecutive WIDTH-bit words, one word per accepted write beat, and pulses a completion flag. It sits between the spiker core output and the spikes_result register bank.

---
 rtl/spiker_writer_pkg.sv | 20 ++
 rtl/spiker_writer_if.sv | 36 +++
 rtl/spiker_popcount.sv | 18 +
 rtl/spiker_writer.sv | 106 ++++++++++
 4 files changed

// File: rtl/spiker_writer_pkg.sv
// Shared types and sizing helpers for the spiker_writer return-path packer.
package spiker_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of register words needed to hold n_spikes bits.
  function automatic int unsigned n_words(input int unsigned n_spikes, input int unsigned width);
    return (n_spikes + width - 1) / width;
  endfunction

  // Index width that still yields one bit for a single-word bank.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spiker_writer_if.sv
// Core-side result handshake plus register-file write bus of spiker_writer.
interface spiker_writer_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_SPIKES = 784
) ();
  import spiker_writer_pkg::*;

  localparam int unsigned N_WORDS = n_words(N_SPIKES, WIDTH);
  localparam int unsigned IW      = idx_w(N_WORDS);
  localparam int unsigned CW      = $clog2(N_SPIKES + 1);

  logic                spk_valid_i;
  logic                spk_ready_o;
  logic [N_SPIKES-1:0] spk_data_i;
  logic                abort_i;
  logic                wr_valid_o;
  logic                wr_ready_i;
  logic [IW-1:0]       wr_idx_o;
  logic [WIDTH-1:0]    wr_data_o;
  logic                busy_o;
  logic                done_o;
  logic [CW-1:0]       spike_count_o;

  // Writer side.
  modport master (
    input  spk_valid_i, spk_data_i, abort_i, wr_ready_i,
    output spk_ready_o, wr_valid_o, wr_idx_o, wr_data_o, busy_o, done_o, spike_count_o
  );

  // Core / register-file side.
  modport slave (
    output spk_valid_i, spk_data_i, abort_i, wr_ready_i,
    input  spk_ready_o, wr_valid_o, wr_idx_o, wr_data_o, busy_o, done_o, spike_count_o
  );

endinterface

// File: rtl/spiker_popcount.sv
// Combinational population count of one WIDTH-bit word.
module spiker_popcount #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]           data,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count = count + PW'(data[i]);
    end
  end

endmodule

// File: rtl/spiker_writer.sv
// Packs one spike result vector into consecutive register words.
// Optional spike counting is enabled by defining SPIKER_WRITER_POPCOUNT_EN.
module spiker_writer
  import spiker_writer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_SPIKES = 784
) (
  input  logic           clk_i,
  input  logic           rst_i,
  spiker_writer_if.master bus
);

  localparam int unsigned N_WORDS = n_words(N_SPIKES, WIDTH);
  localparam int unsigned IW      = idx_w(N_WORDS);
  localparam int unsigned SW      = N_WORDS * WIDTH;
  localparam int unsigned CW      = $clog2(N_SPIKES + 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [IW-1:0]   idx_q, idx_d;

`ifdef SPIKER_WRITER_POPCOUNT_EN
  localparam int unsigned PW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] word_pop;

  spiker_popcount #(.WIDTH(WIDTH)) u_popcount (
    .data  (shadow_q[WIDTH-1:0]),
    .count (word_pop)
  );
`endif

  // Next-state and datapath update; abort wins over the last-word transition.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
`ifdef SPIKER_WRITER_POPCOUNT_EN
    count_d  = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.spk_valid_i) begin
          shadow_d = SW'(bus.spk_data_i);
          idx_d    = '0;
`ifdef SPIKER_WRITER_POPCOUNT_EN
          count_d  = '0;
`endif
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.wr_ready_i) begin
          shadow_d = shadow_q >> WIDTH;
          idx_d    = idx_q + IW'(1);
`ifdef SPIKER_WRITER_POPCOUNT_EN
          count_d  = count_q + CW'(word_pop);
`endif
          if (idx_q == IW'(N_WORDS - 1)) begin
            state_d = ST_DONE;
          end
        end
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
`ifdef SPIKER_WRITER_POPCOUNT_EN
      count_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
`ifdef SPIKER_WRITER_POPCOUNT_EN
      count_q  <= count_d;
`endif
    end
  end

  // Every output is a register or a direct state decode.
  assign bus.spk_ready_o = (state_q == ST_IDLE);
  assign bus.wr_valid_o  = (state_q == ST_WRITE);
  assign bus.busy_o      = (state_q == ST_WRITE);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.wr_idx_o    = idx_q;
  assign bus.wr_data_o   = shadow_q[WIDTH-1:0];

`ifdef SPIKER_WRITER_POPCOUNT_EN
  assign bus.spike_count_o = count_q;
`else
  assign bus.spike_count_o = '0;
`endif

endmodule
